sdrc_addr_split: RTL and testbench

Request-splitting front end of the SDRAM controller, immediately upstream of the bank/command stage. Accepts linear application requests (address, length, direction), maps each address to row/bank/column according to `cfg_colbits`, and issues one or more page-bounded sub-requests to the bank stage. A request that crosses a column-page boundary is split at that boundary; subsequent chunks roll into the next bank or row.

---
 rtl/sdrc_addr_split.sv | 156 +++++++++++++++
 tb/tb_sdrc_addr_split.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdrc_addr_split.sv
// Request-splitting front end of the SDRAM controller: maps linear word addresses
// to row/bank/column and issues page-bounded sub-requests to the bank stage.
module sdrc_addr_split #(
  parameter int unsigned APP_AW = 26,
  parameter int unsigned LEN_W  = 7
) (
  input  logic              sdram_clk,
  input  logic              sdram_resetn,
  input  logic [1:0]        cfg_colbits,
  input  logic              app_req,
  input  logic [APP_AW-1:0] app_req_addr,
  input  logic [LEN_W-1:0]  app_req_len,
  input  logic              app_req_wr_n,
  output logic              app_req_ack,
  output logic              b_req,
  output logic [12:0]       b_row,
  output logic [1:0]        b_bank,
  output logic [10:0]       b_col,
  output logic [LEN_W-1:0]  b_len,
  output logic              b_wr_n,
  output logic              b_last,
  input  logic              b_req_ack,
  output logic              busy
);

  localparam int unsigned ARITH_W = (LEN_W > 12) ? LEN_W : 12;

  typedef enum logic [1:0] {IDLE, CALC, ISSUE} state_t;

  state_t              state_q, state_d;
  logic [APP_AW-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [1:0]          cfg_q, cfg_d;
  logic                wr_n_q, wr_n_d;

  logic                app_req_ack_d, b_req_d, b_wr_n_d, b_last_d, busy_d;
  logic [12:0]         b_row_d;
  logic [1:0]          b_bank_d;
  logic [10:0]         b_col_d;
  logic [LEN_W-1:0]    b_len_d;

  logic [3:0]          col_w;
  logic [10:0]         col_mask, calc_col;
  logic [12:0]         calc_row;
  logic [1:0]          calc_bank;
  logic [ARITH_W-1:0]  room;
  logic [LEN_W-1:0]    chunk_len;

  // State register
  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) state_q <= IDLE;
    else               state_q <= state_d;
  end

  // Next-state logic; b_req is always 1 in ISSUE, so b_req_ack alone marks acceptance
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (app_req) state_d = CALC;
      CALC:    state_d = ISSUE;
      ISSUE:   if (b_req_ack) state_d = b_last ? IDLE : CALC;
      default: state_d = IDLE;
    endcase
  end

  // Address map and chunk size for the current address, from the latched column width
  always_comb begin
    col_w    = 4'd8 + 4'(cfg_q);
    col_mask = 11'((12'd1 << col_w) - 12'd1);
    calc_col = addr_q[10:0] & col_mask;
    unique case (cfg_q)
      2'd0:    begin calc_row = addr_q[22:10]; calc_bank = addr_q[9:8];   end
      2'd1:    begin calc_row = addr_q[23:11]; calc_bank = addr_q[10:9];  end
      2'd2:    begin calc_row = addr_q[24:12]; calc_bank = addr_q[11:10]; end
      default: begin calc_row = addr_q[25:13]; calc_bank = addr_q[12:11]; end
    endcase
    room      = (ARITH_W'(1) << col_w) - ARITH_W'(calc_col);
    // room is below remaining in the else arm, so it fits in LEN_W
    chunk_len = (ARITH_W'(rem_q) < room) ? rem_q : LEN_W'(room);
  end

  // Output and datapath next values
  always_comb begin
    addr_d        = addr_q;
    rem_d         = rem_q;
    cfg_d         = cfg_q;
    wr_n_d        = wr_n_q;
    app_req_ack_d = 1'b0;
    b_req_d       = b_req;
    b_row_d       = b_row;
    b_bank_d      = b_bank;
    b_col_d       = b_col;
    b_len_d       = b_len;
    b_wr_n_d      = b_wr_n;
    b_last_d      = b_last;
    busy_d        = (state_d != IDLE);
    unique case (state_q)
      IDLE: if (app_req) begin
        addr_d        = app_req_addr;
        rem_d         = (app_req_len == '0) ? LEN_W'(1) : app_req_len;
        cfg_d         = cfg_colbits;
        wr_n_d        = app_req_wr_n;
        app_req_ack_d = 1'b1;
      end
      CALC: begin
        b_req_d  = 1'b1;
        b_row_d  = calc_row;
        b_bank_d = calc_bank;
        b_col_d  = calc_col;
        b_len_d  = chunk_len;
        b_wr_n_d = wr_n_q;
        b_last_d = (chunk_len == rem_q);
      end
      ISSUE: if (b_req_ack) begin
        b_req_d = 1'b0;
        addr_d  = addr_q + APP_AW'(b_len);
        rem_d   = rem_q - b_len;
      end
      default: ;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      addr_q      <= '0;
      rem_q       <= '0;
      cfg_q       <= '0;
      wr_n_q      <= 1'b0;
      app_req_ack <= 1'b0;
      b_req       <= 1'b0;
      b_row       <= '0;
      b_bank      <= '0;
      b_col       <= '0;
      b_len       <= '0;
      b_wr_n      <= 1'b0;
      b_last      <= 1'b0;
      busy        <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      cfg_q       <= cfg_d;
      wr_n_q      <= wr_n_d;
      app_req_ack <= app_req_ack_d;
      b_req       <= b_req_d;
      b_row       <= b_row_d;
      b_bank      <= b_bank_d;
      b_col       <= b_col_d;
      b_len       <= b_len_d;
      b_wr_n      <= b_wr_n_d;
      b_last      <= b_last_d;
      busy        <= busy_d;
    end
  end

endmodule

// File: tb/tb_sdrc_addr_split.sv
// Directed bench for sdrc_addr_split: address map, page splitting, backpressure,
// config latching, wrap, zero length, back-to-back spacing and mid-request reset.
module tb_sdrc_addr_split;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  cfg_colbits;
  logic        app_req;
  logic [25:0] app_req_addr;
  logic [6:0]  app_req_len;
  logic        app_req_wr_n;
  logic        app_req_ack;
  logic        b_req;
  logic [12:0] b_row;
  logic [1:0]  b_bank;
  logic [10:0] b_col;
  logic [6:0]  b_len;
  logic        b_wr_n;
  logic        b_last;
  logic        b_req_ack;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [35:0] obs;
  logic [37:0] all_out;
  assign obs     = {b_req, b_row, b_bank, b_col, b_len, b_wr_n, b_last};
  assign all_out = {app_req_ack, b_req, b_row, b_bank, b_col, b_len, b_wr_n, b_last, busy};

  sdrc_addr_split #(.APP_AW(26), .LEN_W(7)) dut (
    .sdram_clk    (clk),
    .sdram_resetn (rst_n),
    .cfg_colbits  (cfg_colbits),
    .app_req      (app_req),
    .app_req_addr (app_req_addr),
    .app_req_len  (app_req_len),
    .app_req_wr_n (app_req_wr_n),
    .app_req_ack  (app_req_ack),
    .b_req        (b_req),
    .b_row        (b_row),
    .b_bank       (b_bank),
    .b_col        (b_col),
    .b_len        (b_len),
    .b_wr_n       (b_wr_n),
    .b_last       (b_last),
    .b_req_ack    (b_req_ack),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [35:0] chunk_v(input logic [12:0] row, input logic [1:0] bank,
                                          input logic [10:0] col, input logic [6:0] len,
                                          input logic wr_n, input logic last);
    return {1'b1, row, bank, col, len, wr_n, last};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [1:0] cfg, input logic [25:0] addr,
                           input logic [6:0] len, input logic wr_n);
    cfg_colbits  = cfg;
    app_req_addr = addr;
    app_req_len  = len;
    app_req_wr_n = wr_n;
    app_req      = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; app_req = 1'b0; b_req_ack = 1'b0;
    cfg_colbits = 2'd0; app_req_addr = '0; app_req_len = '0; app_req_wr_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (all_out !== 38'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h exp 0", all_out);
    end
    #3 rst_n = 1'b1;
    step();
    n_checks++;
    if (all_out !== 38'd0) begin
      n_fail++; $display("FAIL reset_idle: got %h exp 0", all_out);
    end
  endtask

  task automatic test_single();
    b_req_ack = 1'b1;
    drive_req(2'd0, 26'h480, 7'd16, 1'b0);
    step();
    n_checks++;
    if ({app_req_ack, busy, b_req} !== 3'b110) begin
      n_fail++; $display("FAIL single_ack: got %b exp 110", {app_req_ack, busy, b_req});
    end
    app_req = 1'b0;
    step();
    n_checks++;
    if ({obs, app_req_ack} !== {chunk_v(13'd1, 2'd0, 11'h080, 7'd16, 1'b0, 1'b1), 1'b0}) begin
      n_fail++; $display("FAIL single_chunk: got %h exp %h", obs, chunk_v(13'd1, 2'd0, 11'h080, 7'd16, 1'b0, 1'b1));
    end
    step();
    n_checks++;
    if ({b_req, busy, app_req_ack} !== 3'b000) begin
      n_fail++; $display("FAIL single_done: got %b exp 000", {b_req, busy, app_req_ack});
    end
    step();
    n_checks++;
    if ({b_req, app_req_ack} !== 2'b00) begin
      n_fail++; $display("FAIL single_no_reissue: got %b exp 00", {b_req, app_req_ack});
    end
  endtask

  // Page split under backpressure, cfg change mid-request, queued colbits=11 request
  task automatic test_split_backpressure();
    b_req_ack = 1'b0;
    drive_req(2'd0, 26'h0F8, 7'd16, 1'b0);
    step();
    n_checks++;
    if ({app_req_ack, busy} !== 2'b11) begin
      n_fail++; $display("FAIL split_ack: got %b exp 11", {app_req_ack, busy});
    end
    app_req = 1'b0;
    step();
    n_checks++;
    if (obs !== chunk_v(13'd0, 2'd0, 11'h0F8, 7'd8, 1'b0, 1'b0)) begin
      n_fail++; $display("FAIL split_c1: got %h exp %h", obs, chunk_v(13'd0, 2'd0, 11'h0F8, 7'd8, 1'b0, 1'b0));
    end
    drive_req(2'd3, 26'h1FFF, 7'd3, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if ({obs, busy, app_req_ack} !== {chunk_v(13'd0, 2'd0, 11'h0F8, 7'd8, 1'b0, 1'b0), 1'b1, 1'b0}) begin
        n_fail++; $display("FAIL split_hold[%0d]: got %h/%b%b", i, obs, busy, app_req_ack);
      end
    end
    b_req_ack = 1'b1;
    step();
    n_checks++;
    if ({b_req, busy, app_req_ack} !== 3'b010) begin
      n_fail++; $display("FAIL split_bubble: got %b exp 010", {b_req, busy, app_req_ack});
    end
    step();
    n_checks++;
    if ({obs, app_req_ack} !== {chunk_v(13'd0, 2'd1, 11'h000, 7'd8, 1'b0, 1'b1), 1'b0}) begin
      n_fail++; $display("FAIL split_c2: got %h exp %h", obs, chunk_v(13'd0, 2'd1, 11'h000, 7'd8, 1'b0, 1'b1));
    end
    step();
    n_checks++;
    if ({b_req, busy, app_req_ack} !== 3'b000) begin
      n_fail++; $display("FAIL split_idle: got %b exp 000", {b_req, busy, app_req_ack});
    end
    step();
    n_checks++;
    if ({app_req_ack, busy} !== 2'b11) begin
      n_fail++; $display("FAIL c11_ack: got %b exp 11", {app_req_ack, busy});
    end
    app_req = 1'b0;
    step();
    n_checks++;
    if (obs !== chunk_v(13'd0, 2'd3, 11'h7FF, 7'd1, 1'b1, 1'b0)) begin
      n_fail++; $display("FAIL c11_c1: got %h exp %h", obs, chunk_v(13'd0, 2'd3, 11'h7FF, 7'd1, 1'b1, 1'b0));
    end
    step();
    n_checks++;
    if ({b_req, busy} !== 2'b01) begin
      n_fail++; $display("FAIL c11_bubble: got %b exp 01", {b_req, busy});
    end
    step();
    n_checks++;
    if (obs !== chunk_v(13'd1, 2'd0, 11'h000, 7'd2, 1'b1, 1'b1)) begin
      n_fail++; $display("FAIL c11_c2: got %h exp %h", obs, chunk_v(13'd1, 2'd0, 11'h000, 7'd2, 1'b1, 1'b1));
    end
    step();
    n_checks++;
    if ({b_req, busy} !== 2'b00) begin
      n_fail++; $display("FAIL c11_idle: got %b exp 00", {b_req, busy});
    end
  endtask

  // Top-of-space wrap to address 0, then a zero-length request
  task automatic test_wrap_len0();
    b_req_ack = 1'b1;
    drive_req(2'd3, 26'h3FFFFFF, 7'd2, 1'b0);
    step();
    app_req = 1'b0;
    step();
    n_checks++;
    if (obs !== chunk_v(13'h1FFF, 2'd3, 11'h7FF, 7'd1, 1'b0, 1'b0)) begin
      n_fail++; $display("FAIL wrap_c1: got %h exp %h", obs, chunk_v(13'h1FFF, 2'd3, 11'h7FF, 7'd1, 1'b0, 1'b0));
    end
    step();
    step();
    n_checks++;
    if (obs !== chunk_v(13'd0, 2'd0, 11'h000, 7'd1, 1'b0, 1'b1)) begin
      n_fail++; $display("FAIL wrap_c2: got %h exp %h", obs, chunk_v(13'd0, 2'd0, 11'h000, 7'd1, 1'b0, 1'b1));
    end
    step();
    drive_req(2'd0, 26'h123, 7'd0, 1'b1);
    step();
    n_checks++;
    if (app_req_ack !== 1'b1) begin
      n_fail++; $display("FAIL len0_ack: got %b exp 1", app_req_ack);
    end
    app_req = 1'b0;
    step();
    n_checks++;
    if (obs !== chunk_v(13'd0, 2'd1, 11'h023, 7'd1, 1'b1, 1'b1)) begin
      n_fail++; $display("FAIL len0_chunk: got %h exp %h", obs, chunk_v(13'd0, 2'd1, 11'h023, 7'd1, 1'b1, 1'b1));
    end
    step();
    n_checks++;
    if ({b_req, busy} !== 2'b00) begin
      n_fail++; $display("FAIL len0_idle: got %b exp 00", {b_req, busy});
    end
  endtask

  // app_req held high continuously: acks arrive exactly 3 cycles apart
  task automatic test_back_to_back();
    b_req_ack = 1'b1;
    drive_req(2'd1, 26'h200, 7'd4, 1'b0);
    step();
    n_checks++;
    if (app_req_ack !== 1'b1) begin
      n_fail++; $display("FAIL b2b_ack1: got %b exp 1", app_req_ack);
    end
    step();
    n_checks++;
    if ({obs, app_req_ack} !== {chunk_v(13'd0, 2'd1, 11'h000, 7'd4, 1'b0, 1'b1), 1'b0}) begin
      n_fail++; $display("FAIL b2b_chunk1: got %h/%b", obs, app_req_ack);
    end
    step();
    n_checks++;
    if ({b_req, busy, app_req_ack} !== 3'b000) begin
      n_fail++; $display("FAIL b2b_gap: got %b exp 000", {b_req, busy, app_req_ack});
    end
    step();
    n_checks++;
    if ({app_req_ack, busy} !== 2'b11) begin
      n_fail++; $display("FAIL b2b_ack2: got %b exp 11", {app_req_ack, busy});
    end
    app_req = 1'b0;
    step();
    n_checks++;
    if (obs !== chunk_v(13'd0, 2'd1, 11'h000, 7'd4, 1'b0, 1'b1)) begin
      n_fail++; $display("FAIL b2b_chunk2: got %h", obs);
    end
    step();
  endtask

  task automatic test_reset_mid();
    b_req_ack = 1'b0;
    drive_req(2'd0, 26'h0F8, 7'd16, 1'b0);
    step();
    app_req = 1'b0;
    step();
    n_checks++;
    if (b_req !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_pending: got %b exp 1", b_req);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (all_out !== 38'd0) begin
      n_fail++; $display("FAIL rstmid_async: got %h exp 0", all_out);
    end
    b_req_ack = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    n_checks++;
    if (all_out !== 38'd0) begin
      n_fail++; $display("FAIL rstmid_after: got %h exp 0", all_out);
    end
    drive_req(2'd0, 26'h480, 7'd16, 1'b0);
    step();
    n_checks++;
    if (app_req_ack !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_ack: got %b exp 1", app_req_ack);
    end
    app_req = 1'b0;
    step();
    n_checks++;
    if (obs !== chunk_v(13'd1, 2'd0, 11'h080, 7'd16, 1'b0, 1'b1)) begin
      n_fail++; $display("FAIL rstmid_chunk: got %h exp %h", obs, chunk_v(13'd1, 2'd0, 11'h080, 7'd16, 1'b0, 1'b1));
    end
    step();
    n_checks++;
    if ({b_req, busy} !== 2'b00) begin
      n_fail++; $display("FAIL rstmid_idle: got %b exp 00", {b_req, busy});
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_split_backpressure();
    test_wrap_len0();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
